// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   IMEM_ADDR_W   - instruction-memory word-address width (PC width)
//   IMEM_DATA_W   - instruction word width
//   IMEM_RESET_PC - PC value loaded at reset
//   fetch_entry_t - one fetched instruction paired with the PC it came from
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;

  localparam logic [IMEM_ADDR_W-1:0] IMEM_RESET_PC = 8'h00;

  typedef struct packed {
    logic [IMEM_ADDR_W-1:0] pc;
    logic [IMEM_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with a single-cycle flush.
// Latency: a push is visible at head after one edge (registered storage, no bypass).
// Backpressure: none internally; the caller must not push when full without popping, nor pop when empty.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   push       - write wdata at the tail this edge
//   pop        - retire the head entry this edge
//   flush      - discard every entry (wins over push/pop)
//   wdata      - entry written on push
//   count      - occupied entries (0..DEPTH)
//   head       - oldest entry; only meaningful while count != 0
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally. When full and
  // popping in the same cycle, wr_ptr == rd_ptr: the slot being written is the
  // one being vacated, so the simultaneous push is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction-memory sequencing and fetch buffer feeding decode.
// Latency: reset release -> out_valid after 1 edge; redirect -> target at out_* after 2 edges.
// Backpressure: out_valid/out_ready; fetch stalls (pc holds) when the buffer is full and not popping.
//
// Ports:
//   clk, rst_n      - clock and asynchronous active-low reset
//   enable          - fetch permitted when high (buffer drains regardless)
//   imem_addr       - word address to the combinational instruction memory (= pc)
//   imem_rdata      - instruction word at imem_addr, same cycle
//   redirect_valid  - load redirect_pc and flush the buffer (highest priority)
//   redirect_pc     - redirect target word address
//   out_valid       - head entry holds a valid instruction
//   out_ready       - decode accepts the head entry
//   out_instr       - head instruction
//   out_pc          - PC of head instruction
//   buf_count       - occupied buffer entries
module instr_fetch_unit
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = IMEM_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_instr,
  output logic [ADDR_W-1:0]      out_pc,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              pop;
  logic              push;
  logic              has_room;
  fetch_entry_t      wentry;
  fetch_entry_t      head;

  assign pop      = out_valid & out_ready;
  // A full buffer that is popping this cycle frees the slot being written.
  assign has_room = (buf_count < CNT_W'(DEPTH)) | pop;
  assign push     = enable & ~redirect_valid & has_room;

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (push) begin
      pc_next = pc + ADDR_W'(1);  // wraps silently at 2^ADDR_W-1
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign imem_addr = pc;

  always_comb begin
    wentry       = '0;
    wentry.pc    = pc;
    wentry.instr = imem_rdata;
  end

  // A pop coinciding with a redirect still completes at decode; the flush
  // only discards what remains behind it.
  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .count (buf_count),
    .head  (head)
  );

  assign out_valid = (buf_count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized traffic.
// Reference model: a queue of {pc, instr} entries and a scalar pc, advanced once per clock.
// Inputs are driven and outputs sampled on the falling edge.
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [1:0]  buf_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  logic [31:0] prog [5];

  // reference model state
  logic [7:0]  m_pc;
  logic [7:0]  q_pc [$];
  logic [31:0] q_in [$];

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .buf_count      (buf_count)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's current state.
  task automatic check_state(input string tag);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, q_pc.size() != 0});
    check({tag, ".count"}, {30'd0, buf_count}, q_pc.size());
    check({tag, ".addr"},  {24'd0, imem_addr}, {24'd0, m_pc});
    if (q_pc.size() != 0) begin
      check({tag, ".pc"},    {24'd0, out_pc}, {24'd0, q_pc[0]});
      check({tag, ".instr"}, out_instr, q_in[0]);
    end
  endtask

  // Called on a falling edge: check, drive, advance the model, wait one clock.
  task automatic cycle(input string tag, input logic en, input logic rdy,
                       input logic rv, input logic [7:0] rpc);
    bit pop, push;
    check_state(tag);
    enable         = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    pop  = (q_pc.size() != 0) && rdy;
    push = en && !rv && ((q_pc.size() < DEPTH) || pop);
    if (rv) begin
      q_pc.delete();
      q_in.delete();
      m_pc = rpc;
    end else begin
      if (pop) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (push) begin
        q_pc.push_back(m_pc);
        q_in.push_back(mem[m_pc]);
        m_pc = m_pc + 8'd1;
      end
    end
    @(negedge clk);
  endtask

  // Assert reset away from the rising edge, check the immediate effect, release on a falling edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n          = 1'b0;
    enable         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    #1;
    check({tag, ".rst_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".rst_count"}, {30'd0, buf_count}, 32'd0);
    check({tag, ".rst_addr"},  {24'd0, imem_addr}, 32'd0);
    q_pc.delete();
    q_in.delete();
    m_pc = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    prog[0] = 32'h20010003;
    prog[1] = 32'h20020009;
    prog[2] = 32'h00221020;
    prog[3] = 32'h00221824;
    prog[4] = 32'h00222025;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 5; i++) mem[i] = prog[i];

    rst_n = 1'b1;
    enable = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    @(negedge clk);

    // 1: streaming from reset
    do_reset("t1");
    check("t1.rst_instr", out_instr, 32'd0);
    check("t1.rst_pc", {24'd0, out_pc}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle("t1", 1'b1, 1'b1, 1'b0, 8'h00);
      check("t1.seq_pc", {24'd0, out_pc}, i);
      check("t1.seq_instr", out_instr, prog[i]);
    end

    // 2: stall then drain in order
    do_reset("t2");
    cycle("t2", 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("t2", 1'b1, 1'b0, 1'b0, 8'h00);
    check("t2.full_count", {30'd0, buf_count}, 32'd2);
    check("t2.full_addr", {24'd0, imem_addr}, 32'd2);
    check("t2.full_pc", {24'd0, out_pc}, 32'd0);
    cycle("t2", 1'b1, 1'b0, 1'b0, 8'h00);
    check("t2.hold_pc", {24'd0, out_pc}, 32'd0);
    check("t2.hold_instr", out_instr, prog[0]);
    for (int i = 0; i < 4; i++) cycle("t2", 1'b1, 1'b1, 1'b0, 8'h00);

    // 3: redirect while full
    do_reset("t3");
    cycle("t3", 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("t3", 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("t3", 1'b1, 1'b0, 1'b1, 8'h03);
    check("t3.flush_valid", {31'd0, out_valid}, 32'd0);
    check("t3.flush_count", {30'd0, buf_count}, 32'd0);
    check("t3.flush_addr", {24'd0, imem_addr}, 32'd3);
    cycle("t3", 1'b1, 1'b0, 1'b0, 8'h00);
    check("t3.tgt_pc", {24'd0, out_pc}, 32'd3);
    check("t3.tgt_instr", out_instr, 32'h00221824);

    // 4: redirect to the top of the address space and wrap
    cycle("t4", 1'b1, 1'b1, 1'b1, 8'hFF);
    check("t4.flush_valid", {31'd0, out_valid}, 32'd0);
    cycle("t4", 1'b1, 1'b1, 1'b0, 8'h00);
    check("t4.pc_ff", {24'd0, out_pc}, 32'hFF);
    cycle("t4", 1'b1, 1'b1, 1'b0, 8'h00);
    check("t4.pc_00", {24'd0, out_pc}, 32'h00);
    cycle("t4", 1'b1, 1'b1, 1'b0, 8'h00);
    check("t4.pc_01", {24'd0, out_pc}, 32'h01);

    // 5: disable with two buffered, drain, resume at the frozen pc
    do_reset("t5");
    cycle("t5", 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("t5", 1'b1, 1'b0, 1'b0, 8'h00);
    cycle("t5", 1'b0, 1'b1, 1'b0, 8'h00);
    cycle("t5", 1'b0, 1'b1, 1'b0, 8'h00);
    check("t5.drain_valid", {31'd0, out_valid}, 32'd0);
    check("t5.frozen_addr", {24'd0, imem_addr}, 32'd2);
    cycle("t5", 1'b0, 1'b1, 1'b0, 8'h00);
    check("t5.still_frozen", {24'd0, imem_addr}, 32'd2);
    cycle("t5", 1'b1, 1'b1, 1'b0, 8'h00);
    check("t5.resume_pc", {24'd0, out_pc}, 32'd2);

    // 6: reset mid-operation with out_valid high
    cycle("t6", 1'b1, 1'b1, 1'b0, 8'h00);
    check("t6.pre_valid", {31'd0, out_valid}, 32'd1);
    do_reset("t6");
    cycle("t6", 1'b1, 1'b1, 1'b0, 8'h00);
    check("t6.first_pc", {24'd0, out_pc}, 32'd0);
    check("t6.first_valid", {31'd0, out_valid}, 32'd1);

    // randomized traffic, including redirects while disabled
    for (int i = 0; i < 400; i++) begin
      cycle("rnd", ($urandom_range(3, 0) != 0), ($urandom_range(9, 0) < 6),
            ($urandom_range(9, 0) == 0), 8'($urandom));
    end
    check_state("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
